alu_issue_stage: RTL and testbench

ID/EX pipeline stage that sits directly upstream of `alu` and drives its `SrcA`, `SrcB` and `Operation` inputs. It captures decoded operands, immediate and ALU operation code from decode under a valid/ready handshake. It resolves read-after-write hazards by forwarding from the EX/MEM and MEM/WB stages. It supports flush for branch redirect and counts downstream back-pressure cycles.

---
 rtl/core_pkg.sv | 27 ++
 rtl/alu_issue_stage_fwd_mux.sv | 39 +++
 rtl/alu_issue_stage.sv | 145 ++++++++++++++
 tb/tb_alu_issue_stage.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: ALU op codes and the forwarding-source select type.
package core_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_EQ  = 4'b1000;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  // The younger producer (EX/MEM) wins when both stages target the same register.
  function automatic fwd_sel_e fwd_select(input logic exmem_hit, input logic memwb_hit);
    if (exmem_hit) begin
      return FWD_EXMEM;
    end else if (memwb_hit) begin
      return FWD_MEMWB;
    end
    return FWD_NONE;
  endfunction

endpackage

// File: rtl/alu_issue_stage_fwd_mux.sv
// Operand forwarding mux: picks EX/MEM, MEM/WB or register-file data for one source.
module fwd_mux
  import core_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] i_rs_addr,
  input  logic [DATA_WIDTH-1:0]     i_rs_data,
  input  logic                      i_exmem_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] i_exmem_rd,
  input  logic [DATA_WIDTH-1:0]     i_exmem_result,
  input  logic                      i_memwb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] i_memwb_rd,
  input  logic [DATA_WIDTH-1:0]     i_memwb_result,
  output logic [DATA_WIDTH-1:0]     o_data_c
);

  logic     w_rs_nonzero;
  logic     w_exmem_hit;
  logic     w_memwb_hit;
  fwd_sel_e w_sel;

  // x0 is hardwired zero, so writes targeting it are never forwarded.
  assign w_rs_nonzero = (i_rs_addr != '0);
  assign w_exmem_hit  = i_exmem_reg_write && (i_exmem_rd == i_rs_addr) && w_rs_nonzero;
  assign w_memwb_hit  = i_memwb_reg_write && (i_memwb_rd == i_rs_addr) && w_rs_nonzero;
  assign w_sel        = fwd_select(w_exmem_hit, w_memwb_hit);

  always_comb begin
    o_data_c = i_rs_data;
    case (w_sel)
      FWD_EXMEM: o_data_c = i_exmem_result;
      FWD_MEMWB: o_data_c = i_memwb_result;
      default:   o_data_c = i_rs_data;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage feeding the ALU: single-entry valid/ready register with
// operand forwarding, flush and a saturating back-pressure counter.
module alu_issue_stage
  import core_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned OPCODE_LENGTH  = 4,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_rs1_data,
  input  logic [DATA_WIDTH-1:0]     in_rs2_data,
  input  logic [DATA_WIDTH-1:0]     in_imm,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs2_addr,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd_addr,
  input  logic                      in_alu_src,
  input  logic [OPCODE_LENGTH-1:0]  in_operation,
  input  logic                      in_reg_write,
  input  logic                      flush,
  input  logic                      exmem_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
  input  logic [DATA_WIDTH-1:0]     exmem_result,
  input  logic                      memwb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
  input  logic [DATA_WIDTH-1:0]     memwb_result,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     SrcA,
  output logic [DATA_WIDTH-1:0]     SrcB,
  output logic [OPCODE_LENGTH-1:0]  Operation,
  output logic [DATA_WIDTH-1:0]     out_store_data,
  output logic [REG_ADDR_WIDTH-1:0] out_rd,
  output logic                      out_reg_write,
  output logic [31:0]               perf_stall_cnt
);

  localparam int unsigned CNT_WIDTH = 32;

  logic                      r_valid;
  logic [DATA_WIDTH-1:0]     r_rs1_data;
  logic [DATA_WIDTH-1:0]     r_rs2_data;
  logic [DATA_WIDTH-1:0]     r_imm;
  logic [REG_ADDR_WIDTH-1:0] r_rs1_addr;
  logic [REG_ADDR_WIDTH-1:0] r_rs2_addr;
  logic [REG_ADDR_WIDTH-1:0] r_rd;
  logic                      r_alu_src;
  logic [OPCODE_LENGTH-1:0]  r_operation;
  logic                      r_reg_write;
  logic [CNT_WIDTH-1:0]      r_stall_cnt;

  logic                      w_in_ready;
  logic                      w_xfer;
  logic                      w_stall;
  logic [DATA_WIDTH-1:0]     w_rs1_fwd;
  logic [DATA_WIDTH-1:0]     w_rs2_fwd;

  assign w_in_ready = !r_valid || out_ready;
  assign w_xfer     = in_valid && w_in_ready;
  assign w_stall    = r_valid && !out_ready;

  // Handshake and payload capture; flush outranks any transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_rs1_addr  <= '0;
      r_rs2_addr  <= '0;
      r_rd        <= '0;
      r_alu_src   <= 1'b0;
      r_operation <= '0;
      r_reg_write <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_xfer) begin
      r_valid     <= 1'b1;
      r_rs1_data  <= in_rs1_data;
      r_rs2_data  <= in_rs2_data;
      r_imm       <= in_imm;
      r_rs1_addr  <= in_rs1_addr;
      r_rs2_addr  <= in_rs2_addr;
      r_rd        <= in_rd_addr;
      r_alu_src   <= in_alu_src;
      r_operation <= in_operation;
      r_reg_write <= in_reg_write;
    end else if (out_ready && r_valid) begin
      r_valid <= 1'b0;
    end
  end

  // Back-pressure counter saturates rather than wrapping; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_WIDTH{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
    end
  end

  fwd_mux #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_fwd_rs1 (
    .i_rs_addr         (r_rs1_addr),
    .i_rs_data         (r_rs1_data),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_rd        (exmem_rd),
    .i_exmem_result    (exmem_result),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_rd        (memwb_rd),
    .i_memwb_result    (memwb_result),
    .o_data_c          (w_rs1_fwd)
  );

  fwd_mux #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_fwd_rs2 (
    .i_rs_addr         (r_rs2_addr),
    .i_rs_data         (r_rs2_data),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_rd        (exmem_rd),
    .i_exmem_result    (exmem_result),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_rd        (memwb_rd),
    .i_memwb_result    (memwb_result),
    .o_data_c          (w_rs2_fwd)
  );

  assign in_ready       = w_in_ready;
  assign out_valid      = r_valid;
  assign SrcA           = w_rs1_fwd;
  assign SrcB           = r_alu_src ? r_imm : w_rs2_fwd;
  assign Operation      = r_operation;
  assign out_store_data = w_rs2_fwd;
  assign out_rd         = r_rd;
  assign out_reg_write  = r_valid && r_reg_write;
  assign perf_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage.
module tb_alu_issue_stage;
  import core_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic        in_alu_src;
  logic [3:0]  in_operation;
  logic        in_reg_write;
  logic        flush;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] SrcA, SrcB, out_store_data;
  logic [3:0]  Operation;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic [31:0] perf_stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  alu_issue_stage #(
    .DATA_WIDTH     (32),
    .OPCODE_LENGTH  (4),
    .REG_ADDR_WIDTH (5)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_rs1_data     (in_rs1_data),
    .in_rs2_data     (in_rs2_data),
    .in_imm          (in_imm),
    .in_rs1_addr     (in_rs1_addr),
    .in_rs2_addr     (in_rs2_addr),
    .in_rd_addr      (in_rd_addr),
    .in_alu_src      (in_alu_src),
    .in_operation    (in_operation),
    .in_reg_write    (in_reg_write),
    .flush           (flush),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .SrcA            (SrcA),
    .SrcB            (SrcB),
    .Operation       (Operation),
    .out_store_data  (out_store_data),
    .out_rd          (out_rd),
    .out_reg_write   (out_reg_write),
    .perf_stall_cnt  (perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic drive_beat(input logic [4:0] rs1a, input logic [31:0] rs1d,
                            input logic [4:0] rs2a, input logic [31:0] rs2d,
                            input logic [31:0] imm, input logic alu_src,
                            input logic [3:0] op, input logic [4:0] rd, input logic rw);
    in_valid     = 1'b1;
    in_rs1_addr  = rs1a;
    in_rs1_data  = rs1d;
    in_rs2_addr  = rs2a;
    in_rs2_data  = rs2d;
    in_imm       = imm;
    in_alu_src   = alu_src;
    in_operation = op;
    in_rd_addr   = rd;
    in_reg_write = rw;
  endtask

  task automatic clear_fwd();
    exmem_reg_write = 1'b0;
    exmem_rd        = '0;
    exmem_result    = '0;
    memwb_reg_write = 1'b0;
    memwb_rd        = '0;
    memwb_result    = '0;
  endtask

  initial begin
    rst_n        = 1'b1;
    in_valid     = 1'b0;
    in_rs1_data  = '0;
    in_rs2_data  = '0;
    in_imm       = '0;
    in_rs1_addr  = '0;
    in_rs2_addr  = '0;
    in_rd_addr   = '0;
    in_alu_src   = 1'b0;
    in_operation = '0;
    in_reg_write = 1'b0;
    flush        = 1'b0;
    out_ready    = 1'b0;
    clear_fwd();

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_operation", 32'(Operation), 32'd0);
    check("rst_srca", SrcA, 32'd0);
    check("rst_stall_cnt", perf_stall_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic ADD
    @(negedge clk);
    drive_beat(5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 1'b0, ALU_ADD, 5'd3, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    check("add_out_valid", 32'(out_valid), 32'd1);
    check("add_srca", SrcA, 32'd5);
    check("add_srcb", SrcB, 32'd7);
    check("add_operation", 32'(Operation), 32'(ALU_ADD));
    check("add_out_rd", 32'(out_rd), 32'd3);
    check("add_reg_write", 32'(out_reg_write), 32'd1);

    // Back-to-back beat while the first is consumed
    drive_beat(5'd3, 32'h11, 5'd4, 32'h22, 32'd0, 1'b0, ALU_SUB, 5'd5, 1'b1);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_out_valid", 32'(out_valid), 32'd1);
    check("b2b_srca", SrcA, 32'h11);
    check("b2b_operation", 32'(Operation), 32'(ALU_SUB));

    // Forward priority on held rs1=3
    exmem_reg_write = 1'b1; exmem_rd = 5'd3; exmem_result = 32'hAA;
    memwb_reg_write = 1'b1; memwb_rd = 5'd3; memwb_result = 32'hBB;
    #1;
    check("fwd_exmem_prio", SrcA, 32'hAA);
    exmem_reg_write = 1'b0;
    #1;
    check("fwd_memwb", SrcA, 32'hBB);
    check("fwd_no_stall_yet", perf_stall_cnt, 32'd0);

    // rs1=0 never forwards; immediate selects SrcB; store data takes forwarded rs2
    #1;
    exmem_reg_write = 1'b1; exmem_rd = 5'd0; exmem_result = 32'hAA;
    memwb_reg_write = 1'b1; memwb_rd = 5'd3; memwb_result = 32'h1234;
    drive_beat(5'd0, 32'h55, 5'd3, 32'h66, 32'hFFFF_FFFC, 1'b1, ALU_ADD, 5'd6, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    check("x0_srca", SrcA, 32'h55);
    check("imm_srcb", SrcB, 32'hFFFF_FFFC);
    check("imm_store_data", out_store_data, 32'h1234);

    // Back-pressure: 4 stalled cycles with a pending beat
    clear_fwd();
    drive_beat(5'd6, 32'h99, 5'd7, 32'h77, 32'd0, 1'b0, ALU_XOR, 5'd8, 1'b1);
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_srca_stable", SrcA, 32'h55);
      check("bp_stall_cnt", perf_stall_cnt, 32'(i));
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("bp_next_srca", SrcA, 32'h99);
    check("bp_next_srcb", SrcB, 32'h77);
    check("bp_next_operation", 32'(Operation), 32'(ALU_XOR));
    check("bp_next_valid", 32'(out_valid), 32'd1);
    check("bp_cnt_hold", perf_stall_cnt, 32'd4);

    // Flush with a live beat held and a new beat incoming
    drive_beat(5'd9, 32'hDEAD, 5'd10, 32'hBEEF, 32'd0, 1'b0, ALU_EQ, 5'd12, 1'b1);
    flush     = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_reg_write", 32'(out_reg_write), 32'd0);
    check("flush_srca_held", SrcA, 32'h99);
    check("flush_operation_held", 32'(Operation), 32'(ALU_XOR));
    check("flush_cnt_kept", perf_stall_cnt, 32'd5);
    @(negedge clk);
    check("flush_stays_dead", 32'(out_valid), 32'd0);
    check("flush_no_late_beat", SrcA, 32'h99);
    check("flush_cnt_idle", perf_stall_cnt, 32'd5);

    // Async reset mid-stall
    drive_beat(5'd10, 32'h66, 5'd11, 32'h44, 32'd0, 1'b0, ALU_OR, 5'd13, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    check("pre_rst_srca", SrcA, 32'h66);
    @(negedge clk);
    check("pre_rst_cnt", perf_stall_cnt, 32'd6);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_srca", SrcA, 32'd0);
    check("arst_srcb", SrcB, 32'd0);
    check("arst_operation", 32'(Operation), 32'd0);
    check("arst_reg_write", 32'(out_reg_write), 32'd0);
    check("arst_out_rd", 32'(out_rd), 32'd0);
    check("arst_stall_cnt", perf_stall_cnt, 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
